// File: rtl/x1_crtc_timing.sv
// x1_crtc_timing: 6845-style CRTC timing core producing sync, display enable, MA and RA
module x1_crtc_timing #(
  parameter int CHAR_W = 8,
  parameter int MA_W   = 14
) (
  input  logic            I_CLK,
  input  logic            I_RESET,
  input  logic            I_DOT_EN,
  input  logic            I_CS,
  input  logic            I_WR,
  input  logic            I_A,
  input  logic [7:0]      I_D,
  output logic            O_CCLK_EN,
  output logic            O_HSYNC,
  output logic            O_VSYNC,
  output logic            O_DISP,
  output logic [MA_W-1:0] O_MA,
  output logic [4:0]      O_RA
);
  typedef enum logic {ACTIVE, ADJUST} vstate_t;
  localparam int DC_W = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
  logic [4:0]      adr_q;
  logic [7:0]      r0_q, r1_q, r2_q, r3_q, r4_q, r6_q, r7_q, r13_q;
  logic [4:0]      r5_q, r9_q;
  logic [MA_W-9:0] r12_q;
  logic [DC_W-1:0] dc_q, dc_d;
  logic [7:0]      hc_q, hc_d, vc_q, vc_d;
  logic [4:0]      ra_q, ra_d, hs_q, hs_d, vs_q, vs_d, hsw, vsw;
  logic [MA_W-1:0] ma_row_q, ma_row_d, ma_q;
  vstate_t         vst_q, vst_d;
  logic            cclk, line, row_end, last_row, frame_end, to_adj, hs_start;
  logic            hsync_q, vsync_q, disp_q;
  logic [4:0]      ra_o_q;

  // Register port: address latch plus the writable subset of R0..R13
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      adr_q <= 5'd0;
      r0_q  <= 8'd55;
      r1_q  <= 8'd40;
      r2_q  <= 8'd45;
      r3_q  <= 8'h35;
      r4_q  <= 8'd31;
      r5_q  <= 5'd2;
      r6_q  <= 8'd25;
      r7_q  <= 8'd28;
      r9_q  <= 5'd7;
      r12_q <= '0;
      r13_q <= 8'd0;
    end else if (I_CS && I_WR) begin
      if (!I_A) adr_q <= I_D[4:0];
      else begin
        case (adr_q)
          5'd0:    r0_q  <= I_D;
          5'd1:    r1_q  <= I_D;
          5'd2:    r2_q  <= I_D;
          5'd3:    r3_q  <= I_D;
          5'd4:    r4_q  <= I_D;
          5'd5:    r5_q  <= I_D[4:0];
          5'd6:    r6_q  <= I_D;
          5'd7:    r7_q  <= I_D;
          5'd9:    r9_q  <= I_D[4:0];
          5'd12:   r12_q <= I_D[MA_W-9:0];
          5'd13:   r13_q <= I_D;
          default: ;
        endcase
      end
    end
  end

  // Next-state for dot/char/raster/row counters, vertical state and sync pulse counters
  always_comb begin
    hsw       = (r3_q[3:0] == 4'd0) ? 5'd16 : {1'b0, r3_q[3:0]};
    vsw       = (r3_q[7:4] == 4'd0) ? 5'd16 : {1'b0, r3_q[7:4]};
    cclk      = I_DOT_EN && (dc_q == DC_W'(CHAR_W - 1));
    dc_d      = !I_DOT_EN ? dc_q : cclk ? '0 : dc_q + DC_W'(1);
    line      = cclk && (hc_q >= r0_q);
    hc_d      = !cclk ? hc_q : line ? 8'd0 : hc_q + 8'd1;
    row_end   = (vst_q == ACTIVE) && (ra_q >= r9_q);
    last_row  = vc_q >= r4_q;
    to_adj    = row_end && last_row && (r5_q != 5'd0);
    frame_end = (vst_q == ADJUST) ? (({1'b0, ra_q} + 6'd1) >= {1'b0, r5_q})
                                  : (row_end && last_row && (r5_q == 5'd0));
    ra_d      = !line ? ra_q : (frame_end || row_end) ? 5'd0 : ra_q + 5'd1;
    vc_d      = !line ? vc_q : frame_end ? 8'd0 : row_end ? vc_q + 8'd1 : vc_q;
    ma_row_d  = !line ? ma_row_q : frame_end ? {r12_q, r13_q}
                                 : row_end ? ma_row_q + MA_W'(r1_q) : ma_row_q;
    vst_d     = !line ? vst_q : frame_end ? ACTIVE : to_adj ? ADJUST : vst_q;
    hs_start  = cclk && (hc_d == r2_q);
    hs_d      = hs_start ? hsw : (cclk && hs_q != 5'd0) ? hs_q - 5'd1 : hs_q;
    vs_d      = !hs_start ? vs_q : (vs_q != 5'd0) ? vs_q - 5'd1
              : (vst_d == ACTIVE && vc_d == r7_q && ra_d == 5'd0) ? vsw : 5'd0;
  end

  // Counter state and registered outputs; outputs only move on a character clock
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      dc_q     <= '0;
      hc_q     <= 8'd0;
      vc_q     <= 8'd0;
      ra_q     <= 5'd0;
      hs_q     <= 5'd0;
      vs_q     <= 5'd0;
      ma_row_q <= '0;
      vst_q    <= ACTIVE;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b1;
      disp_q   <= 1'b0;
      ma_q     <= '0;
      ra_o_q   <= 5'd0;
    end else begin
      dc_q     <= dc_d;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      ra_q     <= ra_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      ma_row_q <= ma_row_d;
      vst_q    <= vst_d;
      if (cclk) begin
        hsync_q <= hs_d != 5'd0;
        vsync_q <= vs_d == 5'd0;
        disp_q  <= (hc_d < r1_q) && (vc_d < r6_q) && (vst_d == ACTIVE);
        ma_q    <= ma_row_d + MA_W'(hc_d);
        ra_o_q  <= ra_d;
      end
    end
  end

  assign O_CCLK_EN = cclk;
  assign O_HSYNC   = hsync_q;
  assign O_VSYNC   = vsync_q;
  assign O_DISP    = disp_q;
  assign O_MA      = ma_q;
  assign O_RA      = ra_o_q;
endmodule

// File: tb/tb_x1_crtc_timing.sv
// tb_x1_crtc_timing: directed checks of CRTC timing against hand-computed periods and addresses
module tb_x1_crtc_timing;
  localparam int MA_W = 14;
  localparam int LIM  = 20000;
  logic clk = 1'b0;
  logic rst, dot_en, cs, wr_e, a;
  logic [7:0] d;
  logic cclk_en, hsync, vsync, disp;
  logic [MA_W-1:0] ma;
  logic [4:0] ra;
  int total = 0, bad = 0, unstable = 0, ph = 0, div = 1;
  int n, per, lines, ds;

  always #5 clk = ~clk;

  x1_crtc_timing #(.CHAR_W(8), .MA_W(MA_W)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_DOT_EN(dot_en), .I_CS(cs), .I_WR(wr_e), .I_A(a), .I_D(d),
    .O_CCLK_EN(cclk_en), .O_HSYNC(hsync), .O_VSYNC(vsync), .O_DISP(disp), .O_MA(ma), .O_RA(ra)
  );

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int cnt);
    logic [MA_W+7:0] snap;
    for (int i = 0; i < cnt; i++) begin
      dot_en = (ph % div) == 0;
      snap = {hsync, vsync, disp, ma, ra};
      @(posedge clk);
      #1;
      if (!dot_en && snap != {hsync, vsync, disp, ma, ra}) unstable++;
      ph++;
    end
  endtask

  task automatic reg_wr(input logic [4:0] adr, input logic [7:0] dat);
    cs = 1'b1; wr_e = 1'b1; a = 1'b0; d = {3'b000, adr};
    step(1);
    a = 1'b1; d = dat;
    step(1);
    cs = 1'b0; wr_e = 1'b0;
  endtask

  function automatic logic sig(input int s);
    return (s == 0) ? hsync : (s == 1) ? vsync : disp;
  endfunction

  task automatic wait_sig(input int s, input logic v);
    int k = 0;
    while (sig(s) != v && k < LIM) begin step(1); k++; end
    if (sig(s) != v) chk($sformatf("wait_s%0d", s), int'(sig(s)), int'(v));
  endtask

  task automatic width(input int s, input logic v, output int w);
    wait_sig(s, !v);
    wait_sig(s, v);
    w = 0;
    while (sig(s) == v && w < LIM) begin step(1); w++; end
  endtask

  task automatic period(input int s, output int p);
    wait_sig(s, 1'b0);
    wait_sig(s, 1'b1);
    p = 0;
    while (sig(s) == 1'b1 && p < LIM) begin step(1); p++; end
    while (sig(s) == 1'b0 && p < LIM) begin step(1); p++; end
  endtask

  task automatic frame(output int fp, output int fl, output int fd);
    logic prev;
    wait_sig(1, 1'b1);
    wait_sig(1, 1'b0);
    fp = 0; fl = 0; fd = 0; prev = hsync;
    while (vsync == 1'b0 && fp < LIM) begin
      step(1); fp++;
      if (hsync && !prev) fl++;
      prev = hsync; fd += int'(disp);
    end
    while (vsync == 1'b1 && fp < LIM) begin
      step(1); fp++;
      if (hsync && !prev) fl++;
      prev = hsync; fd += int'(disp);
    end
  endtask

  task automatic sync_vs();
    wait_sig(1, 1'b1);
    wait_sig(1, 1'b0);
    chk("vs_hs_align", int'(hsync), 1);
  endtask

  task automatic cfg_small();
    reg_wr(0, 8'd9);  reg_wr(1, 8'd6);  reg_wr(2, 8'd7);  reg_wr(3, 8'h23);
    reg_wr(4, 8'd4);  reg_wr(5, 8'd2);  reg_wr(6, 8'd3);  reg_wr(7, 8'd3);
    reg_wr(9, 8'd1);  reg_wr(12, 8'd0); reg_wr(13, 8'd0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dot_en = 1'b1; cs = 1'b0; wr_e = 1'b0; a = 1'b0; d = 8'd0;
    step(2);
    chk("rst_hsync", int'(hsync), 0);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_disp", int'(disp), 0);
    chk("rst_ma", int'(ma), 0);
    chk("rst_ra", int'(ra), 0);
    chk("rst_cclk", int'(cclk_en), 0);
    rst = 1'b0;
    step(312);
    chk("def_ma39", int'(ma), 39);
    chk("def_disp_on", int'(disp), 1);
    chk("def_vs_idle", int'(vsync), 1);
    step(8);
    chk("def_ma40", int'(ma), 40);
    chk("def_disp_off", int'(disp), 0);
    step(2816);
    chk("def_ra7", int'(ra), 7);
    chk("def_ma_l7", int'(ma), 0);
    step(448);
    chk("def_ra_row1", int'(ra), 0);
    chk("def_ma_row1", int'(ma), 40);
    chk("def_disp_row1", int'(disp), 1);
    step(312);
    chk("def_ma79", int'(ma), 79);
    step(7);
    chk("cclk_pulse", int'(cclk_en), 1);
    step(1);
    chk("cclk_idle", int'(cclk_en), 0);
    width(0, 1'b1, n);  chk("def_hs_width", n, 40);
    period(0, n);       chk("def_hs_period", n, 448);
    width(2, 1'b1, n);  chk("def_disp_width", n, 320);

    rst = 1'b1; step(1); rst = 1'b0;
    step(319);
    reg_wr(0, 8'd20);
    step(6);
    chk("r0_pre_ma", int'(ma), 40);
    chk("r0_pre_ra", int'(ra), 0);
    step(1);
    chk("r0_wrap_ma", int'(ma), 0);
    chk("r0_wrap_ra", int'(ra), 1);
    step(167);
    chk("r0_line_ma", int'(ma), 20);
    step(1);
    chk("r0_next_ma", int'(ma), 0);
    chk("r0_next_ra", int'(ra), 2);

    cfg_small();
    frame(per, lines, ds);
    sync_vs();
    frame(per, lines, ds);
    chk("sm_frame", per, 960);
    chk("sm_lines", lines, 12);
    chk("sm_disp", ds, 288);
    width(1, 1'b0, n);  chk("sm_vs_width", n, 160);
    width(0, 1'b1, n);  chk("sm_hs_width", n, 24);
    period(0, n);       chk("sm_hs_period", n, 80);

    reg_wr(12, 8'h3F);
    reg_wr(13, 8'hFC);
    sync_vs();
    step(424);
    chk("sa_start", int'(ma), 'h3FFC);
    chk("sa_ra", int'(ra), 0);
    chk("sa_disp", int'(disp), 1);
    step(24);
    chk("sa_top", int'(ma), 'h3FFF);
    step(8);
    chk("sa_wrap", int'(ma), 0);
    step(128);
    chk("sa_row1", int'(ma), 2);

    reg_wr(5, 8'd0);
    frame(per, lines, ds);
    frame(per, lines, ds);
    chk("noadj_frame", per, 800);
    chk("noadj_lines", lines, 10);
    reg_wr(5, 8'd2);

    reg_wr(0, 8'd19);
    reg_wr(4, 8'd9);
    reg_wr(3, 8'h00);
    frame(per, lines, ds);
    frame(per, lines, ds);
    chk("w16_frame", per, 3520);
    chk("w16_lines", lines, 22);
    width(0, 1'b1, n);  chk("w16_hs_width", n, 128);
    width(1, 1'b0, n);  chk("w16_vs_width", n, 2560);

    cfg_small();
    div = 4;
    frame(per, lines, ds);
    frame(per, lines, ds);
    chk("x4_frame", per, 3840);
    chk("x4_lines", lines, 12);
    chk("x4_disp", ds, 1152);
    width(0, 1'b1, n);  chk("x4_hs_width", n, 96);
    period(0, n);       chk("x4_hs_period", n, 320);
    chk("x4_stable", unstable, 0);
    div = 1;

    sync_vs();
    step(284);
    chk("adj_ma", int'(ma), 32);
    chk("adj_ra", int'(ra), 0);
    chk("adj_disp", int'(disp), 0);
    rst = 1'b1;
    step(1);
    chk("rst2_hsync", int'(hsync), 0);
    chk("rst2_vsync", int'(vsync), 1);
    chk("rst2_ma", int'(ma), 0);
    chk("rst2_ra", int'(ra), 0);
    rst = 1'b0;
    reg_wr(14, 8'd3); reg_wr(15, 8'd3); reg_wr(16, 8'd3);
    reg_wr(8, 8'd3);  reg_wr(10, 8'd3); reg_wr(11, 8'd3);
    width(0, 1'b1, n);  chk("rst2_hs_width", n, 40);
    period(0, n);       chk("rst2_hs_period", n, 448);
    width(2, 1'b1, n);  chk("rst2_disp_width", n, 320);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
